dly_line_ctrl: RTL and testbench

DLY_LINE_CTRL -- requirements
Module: dly_line_ctrl

---
 rtl/dly_pkg.sv | 15 +
 rtl/dly_line_ctrl_if.sv | 34 +++
 rtl/srl_nx1.sv | 33 +++
 rtl/dly_line_ctrl.sv | 127 ++++++++++++
 tb/tb_dly_line_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/dly_pkg.sv
// Shared definitions for the delay-line controller.
// Contents:
//   STALL_CNT_W - width of the stall counter output
//   dly_state_e - controller FSM state encoding (FLUSH, FILL, LIVE)
package dly_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_FILL  = 2'd1,
    ST_LIVE  = 2'd2
  } dly_state_e;

endpackage

// File: rtl/dly_line_ctrl_if.sv
// Signal bundle between the delay-line controller and its user.
// Ports (as interface signals):
//   RUN       - shift enable (user -> controller)
//   FLUSH_REQ - clear and refill request (user -> controller)
//   DIN       - serial data in (user -> controller)
//   DOUT      - delay-line tap (controller -> user)
//   DOUT_VLD  - DOUT carries real delayed data
//   BUSY      - controller is flushing or filling
//   RDY_PLS   - one-cycle pulse on entering LIVE
//   STALL_CNT - saturating count of stalled LIVE cycles
// master: user side; slave: controller side.
interface dly_line_ctrl_if;
  import dly_pkg::*;

  logic                   RUN;
  logic                   FLUSH_REQ;
  logic                   DIN;
  logic                   DOUT;
  logic                   DOUT_VLD;
  logic                   BUSY;
  logic                   RDY_PLS;
  logic [STALL_CNT_W-1:0] STALL_CNT;

  modport master (
    output RUN, FLUSH_REQ, DIN,
    input  DOUT, DOUT_VLD, BUSY, RDY_PLS, STALL_CNT
  );

  modport slave (
    input  RUN, FLUSH_REQ, DIN,
    output DOUT, DOUT_VLD, BUSY, RDY_PLS, STALL_CNT
  );

endinterface

// File: rtl/srl_nx1.sv
// Depth-stage, 1-bit shift register (SRL-style) with clock enable.
// Ports:
//   CLK - clock
//   CE  - shift enable
//   I   - serial input into stage 0
//   O   - last stage, combinational from the storage
// Contents are deliberately not reset so the structure maps to SRL primitives.
module srl_nx1 #(
  parameter int Depth = 16
) (
  input  logic CLK,
  input  logic CE,
  input  logic I,
  output logic O
);

  logic [Depth-1:0] sr_q;
  logic [Depth-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (CE) begin
      sr_d = {sr_q[Depth-2:0], I};
    end
  end

  always_ff @(posedge CLK) begin
    sr_q <= sr_d;
  end

  assign O = sr_q[Depth-1];

endmodule

// File: rtl/dly_line_ctrl.sv
// Delay-line controller: flushes an SRL with zeros, refills it with live
// data, then passes DIN through with a DEPTH-shift delay.
// Ports:
//   CLK - clock; RST - synchronous active-high reset
//   bus - dly_line_ctrl_if.slave (RUN, FLUSH_REQ, DIN in; DOUT, DOUT_VLD,
//         BUSY, RDY_PLS, STALL_CNT out)
// Optional feature: define DLY_STALL_CNT_EN to build the stall counter;
// otherwise STALL_CNT is tied to zero.
module dly_line_ctrl
  import dly_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 7
) (
  input  logic           CLK,
  input  logic           RST,
  dly_line_ctrl_if.slave bus
);

  dly_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic rdy_q, rdy_d;
  logic srl_ce, srl_i, srl_o;
  logic cnt_done;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  // Equality only: the counter is cleared on every state entry, so it can
  // never pass DEPTH.
  assign cnt_done = (cnt_inc == CNT_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    srl_ce  = 1'b0;
    srl_i   = 1'b0;
    unique case (state_q)
      ST_FLUSH: begin
        // Shift zeros unconditionally; RUN and DIN are ignored here.
        srl_ce = 1'b1;
        srl_i  = 1'b0;
        cnt_d  = cnt_inc;
        if (cnt_done) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        srl_ce = bus.RUN;
        srl_i  = bus.DIN;
        if (bus.RUN) begin
          cnt_d = cnt_inc;
          if (cnt_done) begin
            state_d = ST_LIVE;
            cnt_d   = '0;
          end
        end
      end
      ST_LIVE: begin
        srl_ce = bus.RUN;
        srl_i  = bus.DIN;
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
    endcase
    // A flush request overrides any transition taken above.
    if (bus.FLUSH_REQ) begin
      state_d = ST_FLUSH;
      cnt_d   = '0;
    end
    rdy_d = (state_q == ST_FILL) && (state_d == ST_LIVE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FLUSH;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  srl_nx1 #(
    .Depth(DEPTH)
  ) u_srl (
    .CLK(CLK),
    .CE (srl_ce),
    .I  (srl_i),
    .O  (srl_o)
  );

  assign bus.DOUT     = srl_o;
  assign bus.DOUT_VLD = (state_q == ST_LIVE);
  assign bus.BUSY     = (state_q == ST_FLUSH) || (state_q == ST_FILL);
  assign bus.RDY_PLS  = rdy_q;

`ifdef DLY_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_LIVE) && !bus.RUN && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
    if (bus.FLUSH_REQ) begin
      stall_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.STALL_CNT = stall_q;
`else
  assign bus.STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_dly_line_ctrl.sv
// Directed testbench for dly_line_ctrl with DEPTH=16.
module tb_dly_line_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  dly_line_ctrl_if bus ();

  dly_line_ctrl #(
    .DEPTH(16),
    .CNT_W(7)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.RUN       = 1'b1;
    bus.DIN       = 1'b1;
    bus.FLUSH_REQ = 1'b0;
    rst           = 1'b1;
    tick();
    tick();
    // Reset state
    chk("rst_vld",   {31'd0, bus.DOUT_VLD}, 32'd0);
    chk("rst_busy",  {31'd0, bus.BUSY},     32'd1);
    chk("rst_rdy",   {31'd0, bus.RDY_PLS},  32'd0);
    chk("rst_stall", {16'd0, bus.STALL_CNT}, 32'd0);
    $display("reset checked");

    // Power-up: 16 flush + 16 fill cycles busy, ready in cycle 33
    rst = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      chk("pu_busy", {31'd0, bus.BUSY},    32'd1);
      chk("pu_rdy",  {31'd0, bus.RDY_PLS}, 32'd0);
      tick();
    end
    chk("pu_rdy33", {31'd0, bus.RDY_PLS},  32'd1);
    chk("pu_vld33", {31'd0, bus.DOUT_VLD}, 32'd1);
    chk("pu_dout",  {31'd0, bus.DOUT},     32'd1);
    tick();
    chk("pu_rdy34", {31'd0, bus.RDY_PLS},  32'd0);
    chk("pu_dout34", {31'd0, bus.DOUT},    32'd1);
    $display("power-up fill checked");

    // Clear ones out, then a single pulse must appear 16 cycles later
    bus.DIN = 1'b0;
    for (int j = 0; j < 16; j++) tick();
    chk("zero_dout", {31'd0, bus.DOUT}, 32'd0);
    bus.DIN = 1'b1;
    tick();
    bus.DIN = 1'b0;
    for (int j = 1; j <= 17; j++) begin
      chk("pulse16", {31'd0, bus.DOUT}, (j == 16) ? 32'd1 : 32'd0);
      tick();
    end
    $display("pulse latency 16 checked");

    // Same pulse with 3 stalled cycles: appears at 19, DOUT_VLD stays high
    bus.DIN = 1'b1;
    tick();
    bus.DIN = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      bus.RUN = (j >= 5 && j <= 7) ? 1'b0 : 1'b1;
      chk("pulse19",   {31'd0, bus.DOUT},     (j == 19) ? 32'd1 : 32'd0);
      chk("stall_vld", {31'd0, bus.DOUT_VLD}, 32'd1);
      tick();
    end
    bus.RUN = 1'b1;
    $display("stalled pulse latency 19 checked");

    // Load ones, flush, re-request flush on flush cycle 10
    bus.DIN = 1'b1;
    for (int j = 0; j < 16; j++) tick();
    bus.FLUSH_REQ = 1'b1;
    tick();
    bus.FLUSH_REQ = 1'b0;
    chk("fl_busy", {31'd0, bus.BUSY},     32'd1);
    chk("fl_vld",  {31'd0, bus.DOUT_VLD}, 32'd0);
    for (int j = 0; j < 9; j++) tick();
    bus.FLUSH_REQ = 1'b1;
    tick();
    bus.FLUSH_REQ = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      chk("reflush_busy", {31'd0, bus.BUSY}, 32'd1);
      if (j > 16) chk("fill_dout0", {31'd0, bus.DOUT}, 32'd0);
      tick();
    end
    chk("reflush_rdy",  {31'd0, bus.RDY_PLS}, 32'd1);
    chk("reflush_dout", {31'd0, bus.DOUT},    32'd1);
    $display("flush restart checked");

    // FILL with RUN toggling: LIVE after 31 cycles
    bus.FLUSH_REQ = 1'b1;
    tick();
    bus.FLUSH_REQ = 1'b0;
    for (int j = 0; j < 16; j++) tick();
    for (int j = 1; j <= 31; j++) begin
      bus.RUN = j[0];
      chk("tog_busy", {31'd0, bus.BUSY}, 32'd1);
      tick();
    end
    bus.RUN = 1'b1;
    chk("tog_rdy", {31'd0, bus.RDY_PLS},  32'd1);
    chk("tog_vld", {31'd0, bus.DOUT_VLD}, 32'd1);
    // Repeat, with FLUSH_REQ on the transition cycle
    bus.FLUSH_REQ = 1'b1;
    tick();
    bus.FLUSH_REQ = 1'b0;
    for (int j = 0; j < 16; j++) tick();
    for (int j = 1; j <= 31; j++) begin
      bus.RUN = j[0];
      if (j == 31) bus.FLUSH_REQ = 1'b1;
      tick();
    end
    bus.FLUSH_REQ = 1'b0;
    bus.RUN = 1'b1;
    chk("prio_rdy",  {31'd0, bus.RDY_PLS},  32'd0);
    chk("prio_vld",  {31'd0, bus.DOUT_VLD}, 32'd0);
    chk("prio_busy", {31'd0, bus.BUSY},     32'd1);
    $display("toggled fill and flush priority checked");

    // Back to LIVE (full flush + fill), stall a bit, then reset mid-LIVE
    for (int j = 1; j <= 32; j++) begin
      chk("prio_flush_busy", {31'd0, bus.BUSY}, 32'd1);
      tick();
    end
    chk("live_rdy", {31'd0, bus.RDY_PLS}, 32'd1);
    bus.RUN = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    rst = 1'b1;
    tick();
    chk("mrst_vld",   {31'd0, bus.DOUT_VLD}, 32'd0);
    chk("mrst_busy",  {31'd0, bus.BUSY},     32'd1);
    chk("mrst_stall", {16'd0, bus.STALL_CNT}, 32'd0);
    rst = 1'b0;
    bus.RUN = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      chk("mrst_fill_busy", {31'd0, bus.BUSY}, 32'd1);
      tick();
    end
    chk("mrst_rdy", {31'd0, bus.RDY_PLS}, 32'd1);
    $display("mid-live reset checked");

    // Stall counter
    bus.RUN = 1'b0;
`ifdef DLY_STALL_CNT_EN
    for (int j = 0; j < 70000; j++) tick();
    chk("stall_sat", {16'd0, bus.STALL_CNT}, 32'h0000FFFF);
    chk("stall_vld", {31'd0, bus.DOUT_VLD},  32'd1);
    bus.FLUSH_REQ = 1'b1;
    tick();
    bus.FLUSH_REQ = 1'b0;
    chk("stall_clr", {16'd0, bus.STALL_CNT}, 32'd0);
`else
    for (int j = 0; j < 20; j++) tick();
    chk("stall_off", {16'd0, bus.STALL_CNT}, 32'd0);
    chk("stall_vld", {31'd0, bus.DOUT_VLD},  32'd1);
`endif
    $display("stall counter checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
